// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave to APB bridge: one SETUP/ACCESS per selected transfer, wait states, two-cycle errors.
// Optional macro APB_PSLVERR_EN: report PSLVERR on completion as an AHB ERROR response.
module ahb_apb_bridge #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_cnt;
  logic [31:0]           r_hrdata;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [3:0]            r_pstrb;
  logic [3:0]            w_strb;
  logic                  w_accept;
  logic                  w_open;
  logic                  w_timeout;
  logic                  w_slverr;
  logic                  w_unused;

  assign w_accept  = HSEL & HTRANS[1] & HREADY;
  assign w_open    = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

`ifdef APB_PSLVERR_EN
  assign w_slverr = PSLVERR;
  assign w_unused = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};
`else
  assign w_slverr = 1'b0;
  assign w_unused = ^{HADDR[31:ADDR_WIDTH], HTRANS[0], PSLVERR};
`endif

  always_comb begin
    w_strb = 4'b1111;
    case (HSIZE)
      3'd0:    w_strb = 4'b0001 << HADDR[1:0];
      3'd1:    w_strb = 4'b0011 << {HADDR[1], 1'b0};
      default: w_strb = 4'b1111;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      S_IDLE, S_ERR2: begin
        HRESP = (r_state == S_ERR2);
        if (w_accept) w_next = (HSIZE > 3'd2) ? S_ERR1 : S_SETUP;
        else          w_next = S_IDLE;
      end
      S_SETUP: begin
        PSEL      = 1'b1;
        HREADYOUT = 1'b0;
        w_next    = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYOUT = 1'b0;
        // PREADY takes priority over an expiring timeout in the same cycle
        if (PREADY)         w_next = w_slverr ? S_ERR1 : S_IDLE;
        else if (w_timeout) w_next = S_ERR1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        w_next    = S_ERR2;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hrdata <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pstrb  <= '0;
    end else begin
      r_state <= w_next;
      if (w_open && w_accept) begin
        r_paddr  <= HADDR[ADDR_WIDTH-1:0];
        r_pwrite <= HWRITE;
        r_pstrb  <= HWRITE ? w_strb : 4'b0000;
      end
      if (r_state == S_SETUP)
        r_cnt <= '0;
      else if (r_state == S_ACCESS && !PREADY && !w_timeout)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == S_ACCESS && PREADY && !r_pwrite && !w_slverr)
        r_hrdata <= PRDATA;
    end
  end

  assign HRDATA = r_hrdata;
  assign PADDR  = r_paddr;
  assign PWRITE = r_pwrite;
  assign PSTRB  = r_pstrb;
  assign PWDATA = HWDATA;

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-lite slave that converts each selected AHB-lite transfer into one APB (AMBA 3/4) SETUP/ACCESS access. It sits on one decoder/multiplexer slave port (HSEL_n, HRDATA_n, HREADYOUT_n, HRESP_n) and drives a single downstream APB peripheral. It inserts wait states on the AHB side until APB completes, and maps APB errors to AHB two-cycle error responses.

## Interface
- ADDR_WIDTH, 16: PADDR width, taken from HADDR[ADDR_WIDTH-1:0]
- TIMEOUT, 255: maximum ACCESS cycles with PREADY low before forced error termination; 8-bit counter
- clk  in  1  bus clock, shared with AHB and APB
- reset  in  1  synchronous, active-high reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  address
- HWRITE  in  1  1 = write
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-wide ready from multiplexer
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB byte strobes (all 0 on reads)
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- Transfer accepted when HSEL & HTRANS[1] & HREADY at a rising edge in IDLE or ERR2; HADDR, HWRITE, HSIZE registered. IDLE/BUSY transfers and unselected cycles ignored, OKAY, no wait.
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
- IDLE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accept -> SETUP; accept with HSIZE>2 -> ERR1 (no APB access).
- SETUP: PSEL=1, PENABLE=0, HREADYOUT=0; always -> ACCESS, timeout counter cleared.
- ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. PREADY=1: read -> HRDATA<=PRDATA; PSLVERR counted (see Configuration) -> ERR1, else -> IDLE. PREADY=0: counter increments; counter == TIMEOUT-1 -> ERR1, PSEL dropped.
- ERR1: PSEL=0, HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1; accepts new transfer exactly as IDLE, else -> IDLE.
- PWDATA = HWDATA combinationally (master holds HWDATA stable while HREADYOUT=0).
- PSTRB on writes: HSIZE=0 -> 4'b0001<<HADDR[1:0]; HSIZE=1 -> 4'b0011<<{HADDR[1],1'b0}; HSIZE=2 -> 4'b1111. Reads: 4'b0000.
- PADDR, PWRITE, PSTRB held constant from SETUP through end of ACCESS.
- HRDATA holds last captured value; unchanged on writes and errors.

## Timing
- Reset (synchronous, overrides everything incl. mid-ACCESS): state IDLE, PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PWRITE=0, PSTRB=0, counter=0. Aborted APB access is not completed.
- Address phase cycle N; SETUP N+1; ACCESS N+2; with PREADY=1 at N+2, HREADYOUT=1 at N+3 (two AHB wait states minimum).
- Each PREADY-low cycle in ACCESS adds one wait state.
- Error: HRESP=1 for exactly two cycles, HREADYOUT low then high.
- Back-to-back: new address phase accepted in the HREADYOUT=1 completion cycle; its SETUP follows next cycle, no idle gap.
- PREADY and timeout in same cycle: PREADY wins.

## Configuration
- APB_PSLVERR_EN defined: PSLVERR=1 with PREADY=1 in ACCESS -> ERR1/ERR2 error response.
- Not defined: PSLVERR ignored, completion always OKAY; HSIZE and timeout errors still reported.

## Test plan
- Write 0xDEADBEEF, HADDR=0x0000_0014, HSIZE=2, PREADY=1 -> PADDR=0x0014, PSTRB=4'b1111, PWRITE=1, SETUP then ACCESS, HREADYOUT=1 third cycle after address phase, HRESP=0.
- Read HADDR=0x0008, PRDATA=0x12345678, PREADY low 3 ACCESS cycles -> 5 wait states, HRDATA=0x12345678, OKAY.
- Byte write HADDR=0x0003 HSIZE=0 then halfword HADDR=0x0002 HSIZE=1 back-to-back -> PSTRB 4'b1000 then 4'b1100, second SETUP immediately after first completion.
- PSLVERR=1 with PREADY=1 -> with APB_PSLVERR_EN: HRESP=1 two cycles (HREADYOUT 0,1); without: OKAY.
- HSIZE=3 request -> PSEL stays 0, two-cycle error; PREADY held 0 -> error after TIMEOUT=255 ACCESS cycles, PSEL drops.
- Reset asserted during ACCESS with PREADY=0 -> next cycle IDLE, PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA=0.
